// File: rtl/dmem_access_ctrl_if.sv
// CPU-side request/response handshake and data-memory bus
// for the data-memory access controller.
interface dmem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] memReadData;

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, memReadData,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output memAddr, memWriteData, MemWrite, MemRead
    );

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, memReadData,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  memAddr, memWriteData, MemWrite, MemRead
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: byte/half/word loads and stores,
// sub-word stores as read-modify-write over a registered-read memory.
module dmem_access_ctrl #(
    parameter int DMEM_WORDS  = 1024,
    parameter bit CHECK_RANGE = 1'b1
) (
    input logic clk,
    input logic reset,
    dmem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD1, RD2, WR, DONE} state_t;

    localparam logic [1:0]  SZ_B  = 2'b00;
    localparam logic [1:0]  SZ_H  = 2'b01;
    localparam logic [1:0]  SZ_W  = 2'b10;
    localparam logic [31:0] WORDS = 32'(DMEM_WORDS);

    state_t      state;
    logic        wr_q;
    logic        sgn_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        req_err;
    logic [4:0]  bshift;
    logic [4:0]  hshift;
    logic [31:0] bsel;
    logic [15:0] hsel;
    logic [31:0] ld_data;
    logic [31:0] merged;

    assign bus.req_ready = (state == IDLE) && !reset;

    always_comb begin
        req_err = 1'b0;
        unique case (1'b1)
            bus.req_size == SZ_B: req_err = 1'b0;
            bus.req_size == SZ_H: req_err = bus.req_addr[0];
            bus.req_size == SZ_W: req_err = |bus.req_addr[1:0];
            default:              req_err = 1'b1;
        endcase
        if (CHECK_RANGE && ({2'b00, bus.req_addr[31:2]} >= WORDS))
            req_err = 1'b1;
    end

    // Lane selection is little-endian within the word.
    always_comb begin
        bshift  = {addr_q[1:0], 3'b000};
        hshift  = {addr_q[1], 4'b0000};
        bsel    = bus.memReadData >> bshift;
        hsel    = addr_q[1] ? bus.memReadData[31:16]
                            : bus.memReadData[15:0];
        ld_data = bus.memReadData;
        merged  = bus.memReadData;
        unique case (1'b1)
            size_q == SZ_B: begin
                ld_data = sgn_q ? {{24{bsel[7]}}, bsel[7:0]}
                                : {24'h0, bsel[7:0]};
                merged  = (bus.memReadData & ~(32'hFF << bshift))
                        | ({24'h0, wdata_q[7:0]} << bshift);
            end
            size_q == SZ_H: begin
                ld_data = sgn_q ? {{16{hsel[15]}}, hsel}
                                : {16'h0, hsel};
                merged  = (bus.memReadData & ~(32'hFFFF << hshift))
                        | ({16'h0, wdata_q[15:0]} << hshift);
            end
            default: begin
                ld_data = bus.memReadData;
                merged  = bus.memReadData;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            wr_q             <= 1'b0;
            sgn_q            <= 1'b0;
            size_q           <= 2'b00;
            addr_q           <= 32'h0;
            wdata_q          <= 32'h0;
            bus.resp_valid   <= 1'b0;
            bus.resp_err     <= 1'b0;
            bus.resp_rdata   <= 32'h0;
            bus.memAddr      <= 32'h0;
            bus.memWriteData <= 32'h0;
            bus.MemWrite     <= 1'b0;
            bus.MemRead      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q    <= bus.req_write;
                        sgn_q   <= bus.req_signed;
                        size_q  <= bus.req_size;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (req_err) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            state          <= DONE;
                        end else if (bus.req_write && bus.req_size == SZ_W) begin
                            bus.memAddr      <= {bus.req_addr[31:2], 2'b00};
                            bus.memWriteData <= bus.req_wdata;
                            bus.MemWrite     <= 1'b1;
                            state            <= WR;
                        end else begin
                            bus.memAddr <= {bus.req_addr[31:2], 2'b00};
                            bus.MemRead <= 1'b1;
                            state       <= RD1;
                        end
                    end
                end
                RD1: state <= RD2;
                RD2: begin
                    bus.MemRead <= 1'b0;
                    if (wr_q) begin
                        bus.memWriteData <= merged;
                        bus.MemWrite     <= 1'b1;
                        state            <= WR;
                    end else begin
                        bus.resp_rdata <= ld_data;
                        bus.resp_valid <= 1'b1;
                        state          <= DONE;
                    end
                end
                WR: begin
                    bus.MemWrite   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
